pipelined_instruction_decoder: RTL and testbench
================================================

Name: pipelined_instruction_decoder

Overview:
- Next-generation decode stage for the vector core.
- Buffers fetched instructions in a parametrised FIFO, decodes the FIFO head, and holds the decoded control bundle in an output register.
- Uses a valid/ready handshake on both sides and supports a flush input for taken branches.
- Generalises NIC address decode to N channels. Sits between fetch and the register-read/hazard-detection stage.

Parameters:
- INSTR_W, 32, instruction width (field positions fixed relative to bit 31).
- FIFO_DEPTH, 2, input buffer entries (power of two, >= 2).
- NIC_IDX_W, 2, NIC channel index width, taken from mem_addr[NIC_IDX_W-1:0].
- NIC_TX_CH, 2, only NIC channel that accepts stores.

Ports:
- clk in 1: clock.
- rst_n in 1: asynchronous active-low reset.
- in_valid in 1: fetch offers an instruction.
- in_ready out 1: FIFO not full.
- instr in INSTR_W: instruction word.
- flush in 1: discard all buffered and decoded instructions.
- out_valid out 1: decoded bundle valid.
- out_ready in 1: downstream accepts the bundle.
- rs_a, rs_b out 5: register-read addresses.
- hdu_a, hdu_b out 5: hazard-unit source addresses.
- rd out 5: destination register.
- wr_en out 1: register write enable.
- ww out 2: write width.
- op out 6: ALU operation.
- ppp out 3: participation field.
- br out 2: branch type.
- br_imm out 16: branch immediate.
- mem_addr out 16: memory address.
- mem_en out 1: memory access.
- store_en out 1: store.
- load_sel out 1: load from data memory.
- nic_en out 1: NIC access.
- nic_wr out 1: NIC write.
- nic_addr out NIC_IDX_W: NIC channel.
- load_nic out 1: load from NIC.
- fifo_level out $clog2(FIFO_DEPTH)+1: FIFO occupancy.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, pointers 0, out_valid=0, all bundle outputs 0, fifo_level=0.
- Input side:
  - Accept when in_valid && in_ready.
  - in_ready = !full, combinational from registered level.
  - A push and a pop in the same cycle are both allowed when full; level is unchanged.
- Output register:
  - Loads from the decoded FIFO head when the FIFO is non-empty and (!out_valid || out_ready). The same cycle pops the FIFO.
  - out_valid clears when out_ready && FIFO empty.
  - Bundle is held stable while out_valid && !out_ready.
- Latency: instruction accepted at edge N appears with out_valid at edge N+1 if the path is free. There is no bypass of the FIFO. Throughput is 1 per cycle.
- Pointers wrap modulo FIFO_DEPTH.
- Flush has top priority:
  - Next edge empties the FIFO and clears out_valid and all bundle fields.
  - in_valid in the flush cycle is dropped; in_ready is still driven from current level.
- Decode by opcode instr[31:26]. Unlisted fields are 0.
  - 101010 R-type: rs_a=hdu_a=[20:16]; rs_b=hdu_b=[15:11]; rd=[25:21]; wr_en=1; ppp=[10:8]; ww=[7:6]; op=[5:0].
  - 100010 VBNZ: rs_a=hdu_a=[25:21]; br=10; br_imm=[15:0]; ppp=[10:8].
  - 100011 VBEZ: as VBNZ but br=11.
  - 100000 LD: hdu_a=rd=[25:21]; wr_en=1; mem_en=1; mem_addr=[15:0]; ppp=[10:8].
    - If addr[15:14]==11 and the channel index is non-zero: nic_en=1, load_nic=1, nic_addr=index.
    - Otherwise load_sel=1.
  - 100001 SD: rs_a=hdu_a=[25:21]; mem_en=1; store_en=1; mem_addr=[15:0]; ppp=[10:8].
    - If addr[15:14]==11 and index==NIC_TX_CH: nic_en=1, nic_wr=1, nic_addr=index.
  - 111100 NOP: ppp=[10:8], all else 0.
  - Any other opcode: all fields 0, ppp=0.
- Outputs are glitch-free because all bundle outputs come from registers.

Optional Feature:
- DEC_ILLEGAL_TRAP_EN defined:
  - Adds ports illegal (out 1, registered with the bundle) and illegal_sticky (out 1).
  - illegal=1 for an unlisted opcode.
  - illegal_sticky sets on the first illegal bundle presented, clears only on reset, and is not cleared by flush.
- Undefined: neither port exists; unlisted opcodes decode silently as all-zero.

Decomposition:
- Package decoder_pkg holds:
  - opcode constants OP_RTYPE, OP_VBNZ, OP_VBEZ, OP_LD, OP_SD, OP_NOP;
  - BR_NONE/BR_NZ/BR_EZ encodings;
  - NIC_REGION=2'b11;
  - the decoded-bundle struct typedef.
- One sub-module, decoder_fifo: a generic FIFO_DEPTH x INSTR_W synchronous FIFO with flush and level output. Decode logic is a package function applied to the FIFO head.

Test Plan:
- R-type 0xA8611041, out_ready=1 → one cycle later: out_valid=1, rd=3, rs_a=1, rs_b=2, ww=01, op=000001, wr_en=1, ppp=0.
- LD 0x8080C001 → nic_en=1, load_nic=1, nic_addr=1, load_sel=0, rd=4. LD 0x80800010 → load_sel=1, nic_en=0.
- SD 0x84A0C002 → nic_en=1, nic_wr=1, nic_addr=2, store_en=1, rs_a=5. SD 0x84A0C001 → nic_en=0.
- Hold out_ready=0 and stream 4 instructions:
  - 3 are accepted (2 in FIFO + output register), then in_ready=0 and fifo_level=2.
  - Release out_ready: the 3 emerge in order, then the 4th is accepted.
- Flush with FIFO level 2 and out_valid=1 while in_valid=1 → next cycle level=0, out_valid=0, and the offered instruction never appears.
- Opcode 000000 with DEC_ILLEGAL_TRAP_EN → all fields 0, illegal=1, illegal_sticky stays 1 after flush and clears only on rst_n low.

Source files
------------

// File: rtl/decoder_pkg.sv
// ---------------------------------------------------------------------------
// decoder_pkg
// Shared definitions for the vector-core decode stage:
//   - opcode constants (instr[31:26])
//   - branch-type encodings
//   - NIC address region tag (mem_addr[15:14])
//   - dec_bundle_t : the decoded control bundle held in the output register
//   - decode_instr : pure combinational decode of one 32-bit instruction
// ---------------------------------------------------------------------------
package decoder_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b101010;
  localparam logic [5:0] OP_VBNZ  = 6'b100010;
  localparam logic [5:0] OP_VBEZ  = 6'b100011;
  localparam logic [5:0] OP_LD    = 6'b100000;
  localparam logic [5:0] OP_SD    = 6'b100001;
  localparam logic [5:0] OP_NOP   = 6'b111100;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_NZ   = 2'b10,
    BR_EZ   = 2'b11
  } br_e;

  localparam logic [1:0] NIC_REGION = 2'b11;

  // NIC channel index is carried at full address width; the top trims it
  // to NIC_IDX_W bits on the way out.
  localparam int NIC_ADDR_MAX_W = 16;

  typedef struct packed {
    logic [4:0]                rs_a;
    logic [4:0]                rs_b;
    logic [4:0]                hdu_a;
    logic [4:0]                hdu_b;
    logic [4:0]                rd;
    logic                      wr_en;
    logic [1:0]                ww;
    logic [5:0]                op;
    logic [2:0]                ppp;
    br_e                       br;
    logic [15:0]               br_imm;
    logic [15:0]               mem_addr;
    logic                      mem_en;
    logic                      store_en;
    logic                      load_sel;
    logic                      nic_en;
    logic                      nic_wr;
    logic [NIC_ADDR_MAX_W-1:0] nic_addr;
    logic                      load_nic;
    logic                      illegal;
  } dec_bundle_t;

  // idx_w selects how many low address bits form the NIC channel index;
  // tx_ch is the single channel that accepts stores.
  function automatic dec_bundle_t decode_instr(
    input logic [31:0] ins,
    input int unsigned idx_w,
    input int unsigned tx_ch
  );
    dec_bundle_t d;
    logic [15:0] addr;
    logic [15:0] mask;
    logic [15:0] idx;
    logic        in_nic;
    d      = '0;
    addr   = ins[15:0];
    mask   = 16'((32'd1 << idx_w) - 32'd1);
    idx    = addr & mask;
    in_nic = (addr[15:14] == NIC_REGION);
    case (ins[31:26])
      OP_RTYPE: begin
        d.rs_a  = ins[20:16];
        d.hdu_a = ins[20:16];
        d.rs_b  = ins[15:11];
        d.hdu_b = ins[15:11];
        d.rd    = ins[25:21];
        d.wr_en = 1'b1;
        d.ppp   = ins[10:8];
        d.ww    = ins[7:6];
        d.op    = ins[5:0];
      end
      OP_VBNZ, OP_VBEZ: begin
        d.rs_a   = ins[25:21];
        d.hdu_a  = ins[25:21];
        d.br     = (ins[26]) ? BR_EZ : BR_NZ;
        d.br_imm = ins[15:0];
        d.ppp    = ins[10:8];
      end
      OP_LD: begin
        d.hdu_a    = ins[25:21];
        d.rd       = ins[25:21];
        d.wr_en    = 1'b1;
        d.mem_en   = 1'b1;
        d.mem_addr = addr;
        d.ppp      = ins[10:8];
        // Channel 0 of the NIC region is ordinary data memory.
        if (in_nic && (idx != 16'd0)) begin
          d.nic_en   = 1'b1;
          d.load_nic = 1'b1;
          d.nic_addr = idx;
        end else begin
          d.load_sel = 1'b1;
        end
      end
      OP_SD: begin
        d.rs_a     = ins[25:21];
        d.hdu_a    = ins[25:21];
        d.mem_en   = 1'b1;
        d.store_en = 1'b1;
        d.mem_addr = addr;
        d.ppp      = ins[10:8];
        if (in_nic && (idx == 16'(tx_ch))) begin
          d.nic_en   = 1'b1;
          d.nic_wr   = 1'b1;
          d.nic_addr = idx;
        end
      end
      OP_NOP: begin
        d.ppp = ins[10:8];
      end
      default: begin
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decoder_fifo.sv
// ---------------------------------------------------------------------------
// decoder_fifo
// Generic DEPTH x WIDTH synchronous FIFO with flush and occupancy output.
// DEPTH must be a power of two so pointers wrap naturally.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_flush     : empty the FIFO on the next edge (wins over push/pop)
//   i_push      : write i_data (ignored when full unless popping too)
//   i_pop       : drop the head entry (ignored when empty)
//   o_data      : head entry (valid when !o_empty)
//   o_full      : level == DEPTH
//   o_empty     : level == 0
//   o_level     : current occupancy
// ---------------------------------------------------------------------------
module decoder_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [PTR_W-1:0]            r_wr_ptr;
  logic [PTR_W-1:0]            r_rd_ptr;
  logic [LVL_W-1:0]            r_level;
  logic                        w_do_pop;
  logic                        w_do_push;

  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];

  // A pop frees the slot this same edge, so push-while-full is legal then.
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && (!o_full || w_do_pop) && !i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/pipelined_instruction_decoder.sv
// ---------------------------------------------------------------------------
// pipelined_instruction_decoder
// Vector-core decode stage: fetch -> FIFO -> decode(head) -> output register.
// Optional build macro: DEC_ILLEGAL_TRAP_EN adds illegal / illegal_sticky.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : fetch handshake (in_ready = FIFO not full)
//   instr                 : instruction word
//   flush                 : drop everything buffered and decoded
//   out_valid/out_ready   : downstream handshake for the decoded bundle
//   rs_a, rs_b            : register-read addresses
//   hdu_a, hdu_b          : hazard-unit source addresses
//   rd, wr_en, ww, op     : destination, write enable, width, ALU op
//   ppp                   : participation field
//   br, br_imm            : branch type and immediate
//   mem_addr, mem_en      : memory address / access
//   store_en, load_sel    : store / load from data memory
//   nic_en, nic_wr        : NIC access / write
//   nic_addr, load_nic    : NIC channel / load from NIC
//   fifo_level            : input FIFO occupancy
//   illegal               : (macro) bundle came from an unlisted opcode
//   illegal_sticky        : (macro) an illegal bundle has been presented
// ---------------------------------------------------------------------------
module pipelined_instruction_decoder
  import decoder_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int NIC_IDX_W  = 2,
  parameter int NIC_TX_CH  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INSTR_W-1:0]            instr,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [4:0]                    rs_a,
  output logic [4:0]                    rs_b,
  output logic [4:0]                    hdu_a,
  output logic [4:0]                    hdu_b,
  output logic [4:0]                    rd,
  output logic                          wr_en,
  output logic [1:0]                    ww,
  output logic [5:0]                    op,
  output logic [2:0]                    ppp,
  output logic [1:0]                    br,
  output logic [15:0]                   br_imm,
  output logic [15:0]                   mem_addr,
  output logic                          mem_en,
  output logic                          store_en,
  output logic                          load_sel,
  output logic                          nic_en,
  output logic                          nic_wr,
  output logic [NIC_IDX_W-1:0]          nic_addr,
  output logic                          load_nic,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef DEC_ILLEGAL_TRAP_EN
  ,
  output logic                          illegal,
  output logic                          illegal_sticky
`endif
);

  logic [INSTR_W-1:0] w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_load;
  dec_bundle_t        w_dec;
  dec_bundle_t        r_bundle;
  logic               r_out_valid;

  // in_ready looks only at the registered level, never at out_ready,
  // so there is no combinational path from downstream back to fetch.
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full && !flush;
  assign w_load   = !w_empty && (!r_out_valid || out_ready) && !flush;

  decoder_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_push  (w_push),
    .i_data  (instr),
    .i_pop   (w_load),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  assign w_dec = decode_instr(w_head[31:0], NIC_IDX_W, NIC_TX_CH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_bundle    <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_bundle    <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_bundle    <= w_dec;
    end else if (out_ready) begin
      // Bundle fields are left as-is; only the qualifier drops.
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign rs_a      = r_bundle.rs_a;
  assign rs_b      = r_bundle.rs_b;
  assign hdu_a     = r_bundle.hdu_a;
  assign hdu_b     = r_bundle.hdu_b;
  assign rd        = r_bundle.rd;
  assign wr_en     = r_bundle.wr_en;
  assign ww        = r_bundle.ww;
  assign op        = r_bundle.op;
  assign ppp       = r_bundle.ppp;
  assign br        = r_bundle.br;
  assign br_imm    = r_bundle.br_imm;
  assign mem_addr  = r_bundle.mem_addr;
  assign mem_en    = r_bundle.mem_en;
  assign store_en  = r_bundle.store_en;
  assign load_sel  = r_bundle.load_sel;
  assign nic_en    = r_bundle.nic_en;
  assign nic_wr    = r_bundle.nic_wr;
  assign nic_addr  = r_bundle.nic_addr[NIC_IDX_W-1:0];
  assign load_nic  = r_bundle.load_nic;

  // Bits of the bundle that never reach a port in this build.
  logic w_unused;

`ifdef DEC_ILLEGAL_TRAP_EN
  logic r_illegal_sticky;

  // Sets on the edge the illegal bundle is loaded, i.e. when it is first
  // presented; flush does not touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_illegal_sticky <= 1'b0;
    else if (w_load && w_dec.illegal) r_illegal_sticky <= 1'b1;
  end

  assign illegal        = r_bundle.illegal;
  assign illegal_sticky = r_illegal_sticky;
  assign w_unused       = ^r_bundle.nic_addr[NIC_ADDR_MAX_W-1:NIC_IDX_W];
`else
  assign w_unused = ^{r_bundle.nic_addr[NIC_ADDR_MAX_W-1:NIC_IDX_W], r_bundle.illegal};
`endif

endmodule

// File: tb/tb_pipelined_instruction_decoder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_instruction_decoder
// Directed vectors with hand-computed bundles pushed into a scoreboard queue;
// a monitor pops and compares on every out_valid && out_ready handshake.
// Build with +define+DEC_ILLEGAL_TRAP_EN to exercise the illegal-trap ports.
// ---------------------------------------------------------------------------
module tb_pipelined_instruction_decoder;

  localparam int INSTR_W    = 32;
  localparam int FIFO_DEPTH = 2;
  localparam int NIC_IDX_W  = 2;
  localparam int NIC_TX_CH  = 2;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [4:0]           rs_a;
    logic [4:0]           rs_b;
    logic [4:0]           hdu_a;
    logic [4:0]           hdu_b;
    logic [4:0]           rd;
    logic                 wr_en;
    logic [1:0]           ww;
    logic [5:0]           op;
    logic [2:0]           ppp;
    logic [1:0]           br;
    logic [15:0]          br_imm;
    logic [15:0]          mem_addr;
    logic                 mem_en;
    logic                 store_en;
    logic                 load_sel;
    logic                 nic_en;
    logic                 nic_wr;
    logic [NIC_IDX_W-1:0] nic_addr;
    logic                 load_nic;
    logic                 illegal;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [INSTR_W-1:0]   instr;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [4:0]           rs_a, rs_b, hdu_a, hdu_b, rd;
  logic                 wr_en;
  logic [1:0]           ww;
  logic [5:0]           op;
  logic [2:0]           ppp;
  logic [1:0]           br;
  logic [15:0]          br_imm, mem_addr;
  logic                 mem_en, store_en, load_sel, nic_en, nic_wr, load_nic;
  logic [NIC_IDX_W-1:0] nic_addr;
  logic [LVL_W-1:0]     fifo_level;
`ifdef DEC_ILLEGAL_TRAP_EN
  logic                 illegal;
  logic                 illegal_sticky;
`endif

  int    checks = 0;
  int    errors = 0;
  exp_t  exp_q[$];
  string name_q[$];
  exp_t  e;
  exp_t  m_act;
  exp_t  m_exp;
  string m_name;

  pipelined_instruction_decoder #(
    .INSTR_W    (INSTR_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .NIC_IDX_W  (NIC_IDX_W),
    .NIC_TX_CH  (NIC_TX_CH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .rs_a       (rs_a),
    .rs_b       (rs_b),
    .hdu_a      (hdu_a),
    .hdu_b      (hdu_b),
    .rd         (rd),
    .wr_en      (wr_en),
    .ww         (ww),
    .op         (op),
    .ppp        (ppp),
    .br         (br),
    .br_imm     (br_imm),
    .mem_addr   (mem_addr),
    .mem_en     (mem_en),
    .store_en   (store_en),
    .load_sel   (load_sel),
    .nic_en     (nic_en),
    .nic_wr     (nic_wr),
    .nic_addr   (nic_addr),
    .load_nic   (load_nic),
    .fifo_level (fifo_level)
`ifdef DEC_ILLEGAL_TRAP_EN
    ,
    .illegal        (illegal),
    .illegal_sticky (illegal_sticky)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t observe();
    exp_t a;
    a.rs_a = rs_a;     a.rs_b = rs_b;     a.hdu_a = hdu_a;   a.hdu_b = hdu_b;
    a.rd = rd;         a.wr_en = wr_en;   a.ww = ww;         a.op = op;
    a.ppp = ppp;       a.br = br;         a.br_imm = br_imm; a.mem_addr = mem_addr;
    a.mem_en = mem_en; a.store_en = store_en; a.load_sel = load_sel;
    a.nic_en = nic_en; a.nic_wr = nic_wr; a.nic_addr = nic_addr; a.load_nic = load_nic;
`ifdef DEC_ILLEGAL_TRAP_EN
    a.illegal = illegal;
`else
    a.illegal = 1'b0;
`endif
    return a;
  endfunction

  // Monitor: inputs only change 1ns after posedge, so at negedge the
  // handshake that the coming edge will complete is already visible.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      m_act = observe();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h expected none", m_act);
      end else begin
        m_exp  = exp_q.pop_front();
        m_name = name_q.pop_front();
        if (m_act !== m_exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", m_name, m_act, m_exp);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction; returns 1ns after the edge that accepted it.
  task automatic send(input string nm, input logic [31:0] w, input exp_t x);
    bit acc;
    exp_q.push_back(x);
    name_q.push_back(nm);
    in_valid = 1'b1;
    instr    = w;
    acc      = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got in_ready=0 for 50 cycles expected acceptance", nm);
    end
  endtask

  task automatic drain(input string nm);
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) tick();
    tick();
    check(nm, exp_q.size(), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    instr     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_rd", rd, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_op", op, 0);

    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;

    // Latency: accepted at edge N, presented at edge N+1.
    e = '0; e.rs_a = 1; e.hdu_a = 1; e.rs_b = 2; e.hdu_b = 2; e.rd = 3;
    e.wr_en = 1; e.ww = 2'b01; e.op = 6'b000001;
    send("rtype", 32'hA8611041, e);
    check("lat_level", fifo_level, 1);
    check("lat_valid_early", out_valid, 0);
    tick();
    check("lat_valid", out_valid, 1);
    check("lat_rd", rd, 3);
    drain("drain_rtype");

    // Back-to-back decode vectors.
    e = '0; e.rd = 4; e.hdu_a = 4; e.wr_en = 1; e.mem_en = 1; e.mem_addr = 16'hC001;
    e.nic_en = 1; e.load_nic = 1; e.nic_addr = 1;
    send("ld_nic", 32'h8080C001, e);
    e = '0; e.rd = 4; e.hdu_a = 4; e.wr_en = 1; e.mem_en = 1; e.mem_addr = 16'h0010;
    e.load_sel = 1;
    send("ld_mem", 32'h80800010, e);
    e = '0; e.rd = 4; e.hdu_a = 4; e.wr_en = 1; e.mem_en = 1; e.mem_addr = 16'hC000;
    e.load_sel = 1;
    send("ld_nic_ch0", 32'h8080C000, e);
    e = '0; e.rs_a = 5; e.hdu_a = 5; e.mem_en = 1; e.store_en = 1; e.mem_addr = 16'hC002;
    e.nic_en = 1; e.nic_wr = 1; e.nic_addr = 2;
    send("sd_nic", 32'h84A0C002, e);
    e = '0; e.rs_a = 5; e.hdu_a = 5; e.mem_en = 1; e.store_en = 1; e.mem_addr = 16'hC001;
    send("sd_not_tx", 32'h84A0C001, e);
    e = '0; e.rs_a = 3; e.hdu_a = 3; e.br = 2'b10; e.br_imm = 16'h0534; e.ppp = 5;
    send("vbnz", 32'h88600534, e);
    e = '0; e.rs_a = 3; e.hdu_a = 3; e.br = 2'b11; e.br_imm = 16'hFFFF; e.ppp = 7;
    send("vbez", 32'h8C60FFFF, e);
    e = '0; e.ppp = 3;
    send("nop", 32'hF3FFF3FF, e);
    e = '0;
`ifdef DEC_ILLEGAL_TRAP_EN
    e.illegal = 1;
`endif
    send("illegal_op", 32'h03FFFFFF, e);
    drain("drain_decode");
`ifdef DEC_ILLEGAL_TRAP_EN
    check("sticky_set", illegal_sticky, 1);
`endif

    // Backpressure: 3 accepted, 4th stalls until out_ready returns.
    out_ready = 1'b0;
    e = '0; e.rs_a = 1; e.hdu_a = 1; e.rs_b = 2; e.hdu_b = 2; e.rd = 3;
    e.wr_en = 1; e.ww = 2'b01; e.op = 6'b000001;
    send("stream_a", 32'hA8611041, e);
    e = '0; e.ppp = 1;
    send("stream_b", 32'hF0000100, e);
    e = '0; e.rd = 4; e.hdu_a = 4; e.wr_en = 1; e.mem_en = 1; e.mem_addr = 16'h0010;
    e.load_sel = 1;
    send("stream_c", 32'h80800010, e);
    check("stream_level", fifo_level, 2);
    check("stream_in_ready", in_ready, 0);
    check("stream_valid", out_valid, 1);
    in_valid = 1'b1;
    instr    = 32'h84A0C001;
    tick(); tick(); tick();
    check("stall_in_ready", in_ready, 0);
    check("stall_level", fifo_level, 2);
    check("stall_hold_rd", rd, 3);
    out_ready = 1'b1;
    e = '0; e.rs_a = 5; e.hdu_a = 5; e.mem_en = 1; e.store_en = 1; e.mem_addr = 16'hC001;
    send("stream_d", 32'h84A0C001, e);
    drain("drain_stream");

    // Flush with a full FIFO and a held bundle while fetch offers more.
    out_ready = 1'b0;
    e = '0; e.ppp = 1;
    send("flush_a", 32'hF0000100, e);
    send("flush_b", 32'hF0000100, e);
    send("flush_c", 32'hF0000100, e);
    check("preflush_level", fifo_level, 2);
    in_valid = 1'b1;
    instr    = 32'hABE00000;
    flush    = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    name_q.delete();
    check("flush_level", fifo_level, 0);
    check("flush_valid", out_valid, 0);
    check("flush_ppp", ppp, 0);
    check("flush_in_ready_after", in_ready, 1);
    out_ready = 1'b1;
    repeat (5) tick();
    check("flush_dropped_level", fifo_level, 0);
`ifdef DEC_ILLEGAL_TRAP_EN
    check("sticky_after_flush", illegal_sticky, 1);
`endif
    e = '0; e.ppp = 2;
    send("post_flush", 32'hF0000200, e);
    drain("drain_post_flush");

    // Asynchronous reset mid-cycle with a bundle held.
    out_ready = 1'b0;
    e = '0; e.ppp = 2;
    send("pre_reset", 32'hF0000200, e);
    tick();
    check("pre_reset_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    name_q.delete();
    check("async_rst_valid", out_valid, 0);
    check("async_rst_ppp", ppp, 0);
`ifdef DEC_ILLEGAL_TRAP_EN
    check("async_rst_sticky", illegal_sticky, 0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
